// File: rtl/w5500_spi_target.sv
// SPI target speaking the W5500 frame format (16-bit address, control byte, data bytes).
// It stands in for the real chip: it holds a small common-register memory and strobes out every write.
`timescale 1ns/1ps
module w5500_spi_target #(
  parameter int          ADDR_BITS     = 6,
  parameter int          SYNC_STAGES   = 2,
  parameter logic [7:0]  VERSION_VALUE = 8'h04
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spi_clk,
  input  logic        spi_chip_select_n,
  input  logic        mosi,
  output logic        miso,
  output logic        wr_valid,
  output logic [15:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        frame_done,
  output logic        frame_error,
  output logic        busy
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam logic [15:0] VERSION_ADDR = 16'h0039;

  typedef enum logic [2:0] {S_IDLE, S_HEADER, S_DATA_WR, S_DATA_RD, S_DISCARD} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic sclk_prev_q, sclk_prev_d, cs_prev_q, cs_prev_d;
  logic sclk_s, cs_s, mosi_s, sclk_rise, sclk_fall, cs_rise, cs_fall;

  state_t      state_q, state_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  rx_sr_q, rx_sr_d, tx_sr_q, tx_sr_d;
  logic [15:0] addr_q, addr_d;
  logic [4:0]  bsb_q, bsb_d;
  logic [2:0]  len_q, len_d;
  logic        unlim_q, unlim_d;
  logic        wr_valid_q, wr_valid_d;
  logic [15:0] wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic        frame_done_q, frame_done_d, frame_error_q, frame_error_d;

  logic [7:0]  mem_q [DEPTH];
  logic        mem_we;
  logic [ADDR_BITS-1:0] mem_idx;
  logic [7:0]  mem_wd;

  logic [7:0]  rx_byte, rd_byte;
  logic        in_range, hdr_done;

  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi_clk};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], spi_chip_select_n};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    sclk_s      = sclk_sync_q[SYNC_STAGES-1];
    cs_s        = cs_sync_q[SYNC_STAGES-1];
    mosi_s      = mosi_sync_q[SYNC_STAGES-1];
    sclk_prev_d = sclk_s;
    cs_prev_d   = cs_s;
    sclk_rise   = sclk_s & ~sclk_prev_q;
    sclk_fall   = ~sclk_s & sclk_prev_q;
    cs_rise     = cs_s & ~cs_prev_q;
    cs_fall     = ~cs_s & cs_prev_q;
  end

  always_comb begin
    rx_byte  = {rx_sr_q[6:0], mosi_s};
    in_range = (bsb_q == 5'd0) && (addr_q[15:ADDR_BITS] == '0);
    mem_idx  = addr_q[ADDR_BITS-1:0];
    if (addr_q == VERSION_ADDR) rd_byte = VERSION_VALUE;
    else if (in_range)          rd_byte = mem_q[mem_idx];
    else                        rd_byte = 8'h00;
    hdr_done = (state_q == S_DATA_WR) || (state_q == S_DATA_RD) || (state_q == S_DISCARD);
  end

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    rx_sr_d       = rx_sr_q;
    tx_sr_d       = tx_sr_q;
    addr_d        = addr_q;
    bsb_d         = bsb_q;
    len_d         = len_q;
    unlim_d       = unlim_q;
    wr_valid_d    = 1'b0;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    frame_done_d  = 1'b0;
    frame_error_d = 1'b0;
    mem_we        = 1'b0;
    mem_wd        = rx_byte;

    // CS rising wins over any SCLK edge seen in the same cycle.
    if (cs_rise && state_q != S_IDLE) begin
      state_d   = S_IDLE;
      bit_cnt_d = 5'd0;
      tx_sr_d   = 8'h00;
      if (hdr_done && bit_cnt_q[2:0] == 3'd0)              frame_done_d  = 1'b1;
      else if (!(state_q == S_HEADER && bit_cnt_q == 5'd0)) frame_error_d = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          bit_cnt_d = 5'd0;
          if (cs_fall) state_d = S_HEADER;
        end
        S_HEADER: if (sclk_rise) begin
          rx_sr_d   = rx_byte;
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd7)  addr_d[15:8] = rx_byte;
          if (bit_cnt_q == 5'd15) addr_d[7:0]  = rx_byte;
          if (bit_cnt_q == 5'd23) begin
            bsb_d     = rx_byte[7:3];
            unlim_d   = (rx_byte[1:0] == 2'b00);
            case (rx_byte[1:0])
              2'b01:   len_d = 3'd1;
              2'b10:   len_d = 3'd2;
              2'b11:   len_d = 3'd4;
              default: len_d = 3'd0;
            endcase
            bit_cnt_d = 5'd0;
            state_d   = rx_byte[2] ? S_DATA_WR : S_DATA_RD;
          end
        end
        S_DATA_WR: if (sclk_rise) begin
          rx_sr_d   = rx_byte;
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd7) begin
            bit_cnt_d  = 5'd0;
            wr_valid_d = 1'b1;
            wr_addr_d  = addr_q;
            wr_data_d  = rx_byte;
            mem_we     = in_range && (addr_q != VERSION_ADDR);
            addr_d     = addr_q + 16'd1;
            if (!unlim_q) begin
              len_d = len_q - 3'd1;
              if (len_q == 3'd1) state_d = S_DISCARD;
            end
          end
        end
        S_DATA_RD: begin
          if (sclk_rise) begin
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd7) begin
              bit_cnt_d = 5'd0;
              addr_d    = addr_q + 16'd1;
              if (!unlim_q) begin
                len_d = len_q - 3'd1;
                if (len_q == 3'd1) state_d = S_DISCARD;
              end
            end
          end else if (sclk_fall) begin
            // Load on the byte boundary so the MSB leads the sampling edge by half a period.
            tx_sr_d = (bit_cnt_q[2:0] == 3'd0) ? rd_byte : {tx_sr_q[6:0], 1'b0};
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync_q   <= '0;
      cs_sync_q     <= '1;
      mosi_sync_q   <= '0;
      sclk_prev_q   <= 1'b0;
      cs_prev_q     <= 1'b1;
      state_q       <= S_IDLE;
      bit_cnt_q     <= 5'd0;
      rx_sr_q       <= 8'h00;
      tx_sr_q       <= 8'h00;
      addr_q        <= 16'h0000;
      bsb_q         <= 5'd0;
      len_q         <= 3'd0;
      unlim_q       <= 1'b0;
      wr_valid_q    <= 1'b0;
      wr_addr_q     <= 16'h0000;
      wr_data_q     <= 8'h00;
      frame_done_q  <= 1'b0;
      frame_error_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
    end else begin
      sclk_sync_q   <= sclk_sync_d;
      cs_sync_q     <= cs_sync_d;
      mosi_sync_q   <= mosi_sync_d;
      sclk_prev_q   <= sclk_prev_d;
      cs_prev_q     <= cs_prev_d;
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      rx_sr_q       <= rx_sr_d;
      tx_sr_q       <= tx_sr_d;
      addr_q        <= addr_d;
      bsb_q         <= bsb_d;
      len_q         <= len_d;
      unlim_q       <= unlim_d;
      wr_valid_q    <= wr_valid_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      frame_done_q  <= frame_done_d;
      frame_error_q <= frame_error_d;
      if (mem_we) mem_q[mem_idx] <= mem_wd;
    end
  end

  assign miso        = (state_q == S_DATA_RD) ? tx_sr_q[7] : 1'b0;
  assign busy        = (state_q != S_IDLE);
  assign wr_valid    = wr_valid_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign frame_done  = frame_done_q;
  assign frame_error = frame_error_q;

endmodule

// File: tb/tb_w5500_spi_target.sv
// Closed-loop bench: a bit-banged SPI master drives write/read frames; writes are scoreboarded.
`timescale 1ns/1ps
module tb_w5500_spi_target;

  localparam int HP = 80;

  logic clk = 1'b0, rst, spi_clk, cs_n, mosi;
  logic miso, wr_valid, frame_done, frame_error, busy;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;

  always #5 clk = ~clk;

  w5500_spi_target dut (
    .clk(clk), .rst(rst), .spi_clk(spi_clk), .spi_chip_select_n(cs_n), .mosi(mosi),
    .miso(miso), .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_done(frame_done), .frame_error(frame_error), .busy(busy)
  );

  typedef struct packed { logic [15:0] a; logic [7:0] d; } wr_t;
  typedef struct packed { logic [15:0] a; logic [7:0] c; logic [2:0] n; logic [39:0] d; } fr_t;

  wr_t sb_q[$];
  int total = 0, bad = 0, done_cnt = 0, err_cnt = 0;
  logic [7:0] txb [8];
  logic [7:0] rxb [8];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    wr_t e;
    if (!rst) begin
      if (wr_valid) begin
        if (sb_q.size() == 0) begin
          total++; bad++;
          $display("FAIL wr_unexpected got=%h/%h want=none", wr_addr, wr_data);
        end else begin
          e = sb_q.pop_front();
          chk("wr_addr", 32'(wr_addr), 32'(e.a));
          chk("wr_data", 32'(wr_data), 32'(e.d));
        end
      end
      if (frame_done)  done_cnt++;
      if (frame_error) err_cnt++;
    end
  end

  task automatic send_bits(input int n);
    for (int i = 0; i < n; i++) begin
      mosi = txb[i/8][7-(i%8)];
      #HP; spi_clk = 1'b1;
      rxb[i/8][7-(i%8)] = miso;
      #HP; spi_clk = 1'b0;
    end
  endtask

  task automatic frame(input int n);
    cs_n = 1'b0;
    #HP; send_bits(n);
    #HP; cs_n = 1'b1;
    #(4*HP);
  endtask

  task automatic set_hdr(input logic [15:0] a, input logic [7:0] c);
    for (int i = 0; i < 8; i++) begin txb[i] = 8'h00; rxb[i] = 8'hxx; end
    txb[0] = a[15:8]; txb[1] = a[7:0]; txb[2] = c;
  endtask

  fr_t wt [8];
  fr_t rt [9];
  int d0, e0, lim;
  wr_t w;

  initial begin
    wt[0] = '{16'h0010, 8'h04, 3'd2, 40'hA53C000000};
    wt[1] = '{16'h0039, 8'h04, 3'd1, 40'hFF00000000};
    wt[2] = '{16'h0020, 8'h05, 3'd2, 40'h1122000000};
    wt[3] = '{16'h1000, 8'h04, 3'd1, 40'h7700000000};
    wt[4] = '{16'h003F, 8'h04, 3'd2, 40'h5AC3000000};
    wt[5] = '{16'hFFFF, 8'h04, 3'd2, 40'h0102000000};
    wt[6] = '{16'h0030, 8'h07, 3'd5, 40'h8182838485};
    wt[7] = '{16'h0008, 8'h0C, 3'd1, 40'h9900000000};
    // Expected read data is written out by hand in d.
    rt[0] = '{16'h0010, 8'h00, 3'd2, 40'hA53C000000};
    rt[1] = '{16'h0039, 8'h00, 3'd1, 40'h0400000000};
    rt[2] = '{16'h1000, 8'h00, 3'd1, 40'h0000000000};
    rt[3] = '{16'h0020, 8'h00, 3'd2, 40'h1100000000};
    rt[4] = '{16'h003F, 8'h00, 3'd2, 40'h5A00000000};
    rt[5] = '{16'h0000, 8'h00, 3'd1, 40'h0200000000};
    rt[6] = '{16'h0030, 8'h03, 3'd5, 40'h8182838400};
    rt[7] = '{16'h0008, 8'h00, 3'd1, 40'h0000000000};
    rt[8] = '{16'h0034, 8'h00, 3'd1, 40'h0000000000};

    rst = 1'b1; cs_n = 1'b1; spi_clk = 1'b0; mosi = 1'b0;
    #23;
    chk("rst_miso", 32'(miso), 0);
    chk("rst_wr_valid", 32'(wr_valid), 0);
    chk("rst_wr_addr", 32'(wr_addr), 0);
    chk("rst_wr_data", 32'(wr_data), 0);
    chk("rst_done", 32'(frame_done), 0);
    chk("rst_error", 32'(frame_error), 0);
    chk("rst_busy", 32'(busy), 0);
    #20 rst = 1'b0;
    #100;

    for (int f = 0; f < 8; f++) begin
      set_hdr(wt[f].a, wt[f].c);
      case (wt[f].c[1:0])
        2'b01: lim = 1; 2'b10: lim = 2; 2'b11: lim = 4; default: lim = 99;
      endcase
      for (int k = 0; k < int'(wt[f].n); k++) begin
        txb[3+k] = wt[f].d[39-8*k -: 8];
        if (k < lim) begin
          w.a = wt[f].a + 16'(k);
          w.d = txb[3+k];
          sb_q.push_back(w);
        end
      end
      d0 = done_cnt; e0 = err_cnt;
      frame(24 + 8*int'(wt[f].n));
      chk($sformatf("wr%0d_done", f), 32'(done_cnt - d0), 1);
      chk($sformatf("wr%0d_err", f), 32'(err_cnt - e0), 0);
      chk($sformatf("wr%0d_sb_left", f), 32'(sb_q.size()), 0);
      sb_q.delete();
    end

    for (int f = 0; f < 9; f++) begin
      set_hdr(rt[f].a, rt[f].c);
      d0 = done_cnt;
      frame(24 + 8*int'(rt[f].n));
      chk($sformatf("rd%0d_hdr_miso", f), {8'h00, rxb[0], rxb[1], rxb[2]}, 0);
      for (int k = 0; k < int'(rt[f].n); k++)
        chk($sformatf("rd%0d_byte%0d", f, k), 32'(rxb[3+k]), 32'(rt[f].d[39-8*k -: 8]));
      chk($sformatf("rd%0d_done", f), 32'(done_cnt - d0), 1);
    end

    // Abort inside the header.
    set_hdr(16'h0010, 8'h04);
    d0 = done_cnt; e0 = err_cnt;
    frame(12);
    chk("abort_hdr_err", 32'(err_cnt - e0), 1);
    chk("abort_hdr_done", 32'(done_cnt - d0), 0);

    // Abort mid data byte: the partial byte must not commit.
    set_hdr(16'h0005, 8'h04); txb[3] = 8'hEE;
    d0 = done_cnt; e0 = err_cnt;
    frame(28);
    chk("abort_byte_err", 32'(err_cnt - e0), 1);
    chk("abort_byte_done", 32'(done_cnt - d0), 0);
    set_hdr(16'h0005, 8'h00);
    frame(32);
    chk("abort_byte_mem", 32'(rxb[3]), 0);

    // CS pulse with no clocks.
    d0 = done_cnt; e0 = err_cnt;
    frame(0);
    chk("empty_cs_err", 32'(err_cnt - e0), 0);
    chk("empty_cs_done", 32'(done_cnt - d0), 0);

    // Async reset in the middle of a read of 0010 (holds A5, MSB 1).
    set_hdr(16'h0010, 8'h00);
    d0 = done_cnt; e0 = err_cnt;
    cs_n = 1'b0; #HP;
    send_bits(24);
    #HP;
    chk("midrst_pre_miso", 32'(miso), 1);
    chk("midrst_pre_busy", 32'(busy), 1);
    rst = 1'b1; #1;
    chk("midrst_miso", 32'(miso), 0);
    chk("midrst_busy", 32'(busy), 0);
    cs_n = 1'b1; #100; rst = 1'b0; #200;
    chk("midrst_no_err", 32'(err_cnt - e0), 0);
    chk("midrst_no_done", 32'(done_cnt - d0), 0);
    set_hdr(16'h0010, 8'h00);
    frame(32);
    chk("midrst_mem_cleared", 32'(rxb[3]), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/w5500_spi_target.md
Name: w5500_spi_target

Overview:
- Behavioural-synthesisable SPI target that implements the W5500 SPI frame format: 16-bit address, 8-bit control byte, then N data bytes.
- Serves as the far end of the W5500 driver: it replaces the external chip in closed-loop simulation and on FPGA loopback builds.
- Holds a small common-register byte memory and reports every write on a strobe interface.
- Oversamples the SPI pins with the system clock. SPI mode 0.

Parameters:
- ADDR_BITS, 6, implemented common-register depth is 2**ADDR_BITS bytes.
- SYNC_STAGES, 2, synchroniser flops on spi_clk, spi_chip_select_n and mosi (minimum 2).
- VERSION_VALUE, 8'h04, read-only value returned at address 16'h0039.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- spi_clk  in  1  SPI serial clock from the master; idles low.
- spi_chip_select_n  in  1  active-low frame select.
- mosi  in  1  master-out serial data, MSB first.
- miso  out  1  target-out serial data, MSB first.
- wr_valid  out  1  one-clk pulse per committed write byte.
- wr_addr  out  16  address of the committed byte.
- wr_data  out  8  data of the committed byte.
- frame_done  out  1  one-clk pulse: frame ended cleanly.
- frame_error  out  1  one-clk pulse: frame ended mid-header or mid-byte.
- busy  out  1  high while a frame is open (synchronised CS low).

Behaviour:
- Clock and reset:
  - One clock domain. rst asynchronously clears all state.
  - Reset values: miso=0, wr_valid=0, wr_addr=0, wr_data=0, frame_done=0, frame_error=0, busy=0. All memory bytes are 0.
- Input sampling:
  - All three SPI inputs pass through SYNC_STAGES flops.
  - Rising and falling edges of spi_clk are detected on the synchronised signal.
  - Supported SCLK: high and low phases each at least 4 clk periods.
- Bit and byte handling:
  - mosi is sampled on the detected rising edge.
  - A 5-bit bit counter and an 8-bit shift register assemble each byte.
- States:
  - IDLE: synchronised CS high. miso=0. bit_cnt=0. CS falling moves to HEADER and sets busy.
  - HEADER: receives 24 bits. Bytes 0-1 form addr[15:0]. Byte 2 is control: BSB=ctl[7:3], RWB=ctl[2] (1=write), OM=ctl[1:0]. miso is driven 0 throughout. On the 24th rising edge, remaining length is set from OM (00=unlimited, 01=1, 10=2, 11=4 bytes). RWB=1 moves to DATA_WR; RWB=0 moves to DATA_RD.
  - DATA_WR: on each 8th rising edge, the byte commits and produces a single wr_valid pulse (wr_addr=addr, wr_data=byte). The pulse is emitted for every write byte, even when the memory is not updated. Memory mem[addr] is updated only when BSB=0, addr[15:ADDR_BITS]=0 and addr is not 16'h0039. After each commit, addr increments by 1 (16-bit wrap: FFFF->0000) and length decrements. When length reaches 0 in fixed mode, go to DISCARD.
  - DATA_RD: on a falling edge with bit_cnt mod 8 = 0, load tx_sr with rd_byte(addr); otherwise shift tx_sr left. miso = tx_sr[7]. The first load occurs on the falling edge after bit 24, so the MSB is valid half a period before the sampling edge. rd_byte returns VERSION_VALUE at 16'h0039, mem[addr] for an in-range addr with BSB=0, and 8'h00 otherwise. addr increments on each 8th rising edge. Fixed-length exhaustion moves to DISCARD.
  - DISCARD: further bits are ignored, miso=0, and no writes occur.
- Frame termination: synchronised CS rising returns to IDLE from any state in the same cycle.
  - frame_done pulses if the header was complete and bit_cnt mod 8 = 0.
  - frame_error pulses if 0 < bits < 24, or if a data byte is partial. A partial byte is never committed.
  - A CS pulse with 0 bits produces neither pulse.
- Simultaneous events: a CS rise on the same synchronised cycle as a spi_clk rising edge ignores the edge.
- Mid-frame reset: rst asserted mid-frame aborts the frame with no pulses. Memory is cleared.
- Persistence: memory persists across frames.

Test Plan:
- Write frame: addr 16'h0010, ctl 8'h04 (BSB0, write, VDM), data A5 3C, then CS high -> wr_valid twice: (0010,A5) and (0011,3C); frame_done=1; frame_error=0.
- Read frame: addr 16'h0010, ctl 8'h00, 2 data bytes -> miso bytes captured on rising edges equal A5 then 3C; header bits on miso are all 0.
- VERSIONR: read of 16'h0039 returns 8'h04. A write of 8'hFF to 0039 pulses wr_valid, a subsequent read still returns 8'h04, and a read of 16'h1000 returns 8'h00.
- Fixed length: addr 0020, ctl 8'h05 (write, OM=01), data 11 22 -> one wr_valid (0020,11); mem[0021] remains 00; frame_done=1.
- Abort: CS rises after 12 header bits -> frame_error=1, no wr_valid. CS rises after 28 bits of a write frame -> frame_error=1, no wr_valid for the partial byte.
- Async reset: assert rst mid-read -> miso=0 and busy=0 immediately. A following read of a previously written address returns 00.
